multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: Moore FSM sequencing fetch, decode, memory,
// R-type, branch, jump and immediate instructions, plus a retired-instruction
// counter. Optional macro MC_BNE_EN adds bne (opcode 0x05) through BRANCH.
module multicycle_controller #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         operation,
  input  logic [5:0]         fcn,
  input  logic               MemRdy,
  input  logic               Stall,
  output logic               PCWrt,
  output logic               PCWrtCond,
  output logic               BrNe,
  output logic               IorD,
  output logic               MemRd,
  output logic               MemWrt,
  output logic               IRWrt,
  output logic               MemtReg,
  output logic               destReg,
  output logic               RgWrt,
  output logic               ALUSrcA,
  output logic               ExtSel,
  output logic               Exc,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOperation,
  output logic [3:0]         State,
  output logic [CNT_W-1:0]   InstrCnt
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEXEC   = 4'd11,
    S_IWB     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  state_t             state;
  state_t             next;
  logic               retire;
  logic [CNT_W-1:0]   cnt;

  assign State    = state;
  assign InstrCnt = cnt;

  // State and retirement counter; reset wins over Stall, Stall freezes both.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (!Stall) begin
      state <= next;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; Stall masks the write strobes.
  always_comb begin
    next         = state;
    retire       = 1'b0;
    PCWrt        = 1'b0;
    PCWrtCond    = 1'b0;
    BrNe         = 1'b0;
    IorD         = 1'b0;
    MemRd        = 1'b0;
    MemWrt       = 1'b0;
    IRWrt        = 1'b0;
    MemtReg      = 1'b0;
    destReg      = 1'b0;
    RgWrt        = 1'b0;
    ALUSrcA      = 1'b0;
    ExtSel       = 1'b0;
    Exc          = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    ALUOperation = '0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        MemRd        = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOperation = ALUOP_W'(ALU_ADD);
        IRWrt        = MemRdy;
        PCWrt        = MemRdy;
        if (MemRdy) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB      = 2'b11;
        ALUOperation = ALUOP_W'(ALU_ADD);
        case (operation)
          6'h00:               next = S_EXEC;
          6'h23, 6'h2B:        next = S_MEMADR;
          6'h04:               next = S_BRANCH;
`ifdef MC_BNE_EN
          6'h05:               next = S_BRANCH;
`endif
          6'h02:               next = S_JUMP;
          6'h08, 6'h0C, 6'h0D: next = S_IEXEC;
          default:             next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = ALUOP_W'(ALU_ADD);
        case (operation)
          6'h23:   next = S_MEMRD;
          6'h2B:   next = S_MEMWR;
          default: next = S_ILLEGAL;
        endcase
      end
      S_MEMRD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
        if (MemRdy) next = S_MEMWB;
      end
      S_MEMWB: begin
        RgWrt   = 1'b1;
        MemtReg = 1'b1;
        next    = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        MemWrt = 1'b1;
        IorD   = 1'b1;
        if (MemRdy) begin
          next   = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        next    = S_RWB;
        case (fcn)
          6'h20:   ALUOperation = ALUOP_W'(ALU_ADD);
          6'h22:   ALUOperation = ALUOP_W'(ALU_SUB);
          6'h24:   ALUOperation = ALUOP_W'(ALU_AND);
          6'h25:   ALUOperation = ALUOP_W'(ALU_OR);
          6'h2A:   ALUOperation = ALUOP_W'(ALU_SLT);
          default: next = S_ILLEGAL;
        endcase
      end
      S_RWB: begin
        RgWrt   = 1'b1;
        destReg = 1'b1;
        next    = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALUOP_W'(ALU_SUB);
        PCWrtCond    = 1'b1;
        PCSrc        = 2'b01;
`ifdef MC_BNE_EN
        BrNe         = (operation == 6'h05);
`endif
        next         = S_FETCH;
        retire       = 1'b1;
      end
      S_JUMP: begin
        PCWrt  = 1'b1;
        PCSrc  = 2'b10;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next    = S_IWB;
        case (operation)
          6'h0C: begin
            ALUOperation = ALUOP_W'(ALU_AND);
            ExtSel       = 1'b1;
          end
          6'h0D: begin
            ALUOperation = ALUOP_W'(ALU_OR);
            ExtSel       = 1'b1;
          end
          default: ALUOperation = ALUOP_W'(ALU_ADD);
        endcase
      end
      S_IWB: begin
        RgWrt  = 1'b1;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_ILLEGAL: Exc = 1'b1;
      default: next = S_IDLE;
    endcase
    if (Stall) begin
      PCWrt     = 1'b0;
      PCWrtCond = 1'b0;
      IRWrt     = 1'b0;
      RgWrt     = 1'b0;
      MemWrt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. A second instance with a 4-bit
// counter shares all inputs so counter wrap is reachable in few cycles.
module tb_multicycle_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 4;

  localparam logic [12:0] PCW = 13'h1000;
  localparam logic [12:0] PCC = 13'h0800;
  localparam logic [12:0] BNE = 13'h0400;
  localparam logic [12:0] IOD = 13'h0200;
  localparam logic [12:0] MRD = 13'h0100;
  localparam logic [12:0] MWR = 13'h0080;
  localparam logic [12:0] IRW = 13'h0040;
  localparam logic [12:0] MTR = 13'h0020;
  localparam logic [12:0] DST = 13'h0010;
  localparam logic [12:0] RGW = 13'h0008;
  localparam logic [12:0] ASA = 13'h0004;
  localparam logic [12:0] EXT = 13'h0002;
  localparam logic [12:0] EXC = 13'h0001;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, MemRdy, Stall;
  logic [5:0] operation, fcn;

  logic PCWrt, PCWrtCond, BrNe, IorD, MemRd, MemWrt, IRWrt, MemtReg, destReg;
  logic RgWrt, ALUSrcA, ExtSel, Exc;
  logic [1:0] ALUSrcB, PCSrc;
  logic [AW-1:0] ALUOperation;
  logic [3:0] State;
  logic [CW-1:0] InstrCnt;

  logic s_PCWrt, s_PCWrtCond, s_BrNe, s_IorD, s_MemRd, s_MemWrt, s_IRWrt;
  logic s_MemtReg, s_destReg, s_RgWrt, s_ALUSrcA, s_ExtSel, s_Exc;
  logic [1:0] s_ALUSrcB, s_PCSrc;
  logic [AW-1:0] s_ALUOperation;
  logic [3:0] s_State;
  logic [SW-1:0] s_InstrCnt;

  int tests = 0;
  int failed = 0;
  logic [24:0] exp_v;
  logic [24:0] obs;

  assign obs = {State, PCWrt, PCWrtCond, BrNe, IorD, MemRd, MemWrt, IRWrt, MemtReg,
                destReg, RgWrt, ALUSrcA, ExtSel, Exc, ALUSrcB, PCSrc, ALUOperation};

  multicycle_controller #(.ALUOP_W(AW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .operation(operation), .fcn(fcn), .MemRdy(MemRdy), .Stall(Stall),
    .PCWrt(PCWrt), .PCWrtCond(PCWrtCond), .BrNe(BrNe), .IorD(IorD), .MemRd(MemRd),
    .MemWrt(MemWrt), .IRWrt(IRWrt), .MemtReg(MemtReg), .destReg(destReg), .RgWrt(RgWrt),
    .ALUSrcA(ALUSrcA), .ExtSel(ExtSel), .Exc(Exc), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUOperation(ALUOperation), .State(State), .InstrCnt(InstrCnt)
  );

  multicycle_controller #(.ALUOP_W(AW), .CNT_W(SW)) dut_small (
    .Clk(Clk), .Rst(Rst), .operation(operation), .fcn(fcn), .MemRdy(MemRdy), .Stall(Stall),
    .PCWrt(s_PCWrt), .PCWrtCond(s_PCWrtCond), .BrNe(s_BrNe), .IorD(s_IorD), .MemRd(s_MemRd),
    .MemWrt(s_MemWrt), .IRWrt(s_IRWrt), .MemtReg(s_MemtReg), .destReg(s_destReg),
    .RgWrt(s_RgWrt), .ALUSrcA(s_ALUSrcA), .ExtSel(s_ExtSel), .Exc(s_Exc),
    .ALUSrcB(s_ALUSrcB), .PCSrc(s_PCSrc), .ALUOperation(s_ALUOperation),
    .State(s_State), .InstrCnt(s_InstrCnt)
  );

  function automatic logic [24:0] ev(input logic [3:0] st, input logic [12:0] b,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [3:0] op);
    return {st, b, sb, ps, op};
  endfunction

  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b0; Stall = 1'b0; MemRdy = 1'b0; operation = 6'h00; fcn = 6'h00;
    cyc(); cyc();
    #1 exp_v = ev(4'd0, 13'h0, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd0) begin failed++; $display("FAIL reset_cnt got=%h exp=0", InstrCnt); end
    tests++;
    Rst = 1'b1;
    #1 if (obs !== exp_v) begin failed++; $display("FAIL idle_before_edge got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd1, MRD, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL first_fetch got=%h exp=%h", obs, exp_v); end
    tests++;
  endtask

  task automatic test_fetch_wait;
    MemRdy = 1'b0;
    cyc();
    #1 exp_v = ev(4'd1, MRD, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL fetch_hold got=%h exp=%h", obs, exp_v); end
    tests++;
    MemRdy = 1'b1;
    #1 exp_v = ev(4'd1, MRD | IRW | PCW, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL fetch_rdy got=%h exp=%h", obs, exp_v); end
    tests++;
  endtask

  task automatic test_add;
    operation = 6'h00; fcn = 6'h20; MemRdy = 1'b1;
    cyc();
    #1 exp_v = ev(4'd2, 13'h0, 2'b11, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL add_decode got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd7, ASA, 2'b00, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL add_exec got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd8, RGW | DST, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL add_rwb got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd1, MRD | IRW | PCW, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL add_fetch got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd1) begin failed++; $display("FAIL add_cnt got=%0d exp=1", InstrCnt); end
    tests++;
  endtask

  task automatic test_sub;
    operation = 6'h00; fcn = 6'h22; MemRdy = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4'd7, ASA, 2'b00, 2'b00, 4'd6);
    if (obs !== exp_v) begin failed++; $display("FAIL sub_exec got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc(); cyc();
    #1 if (InstrCnt !== 16'd2) begin failed++; $display("FAIL sub_cnt got=%0d exp=2", InstrCnt); end
    tests++;
  endtask

  task automatic test_lw_wait;
    operation = 6'h23; MemRdy = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4'd3, ASA, 2'b10, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL lw_memadr got=%h exp=%h", obs, exp_v); end
    tests++;
    MemRdy = 1'b0;
    cyc();
    exp_v = ev(4'd4, MRD | IOD, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1 if (obs !== exp_v) begin failed++; $display("FAIL lw_memrd_wait%0d got=%h exp=%h", i, obs, exp_v); end
      tests++;
      cyc();
    end
    MemRdy = 1'b1;
    #1 if (obs !== exp_v) begin failed++; $display("FAIL lw_memrd_done got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd5, RGW | MTR, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL lw_memwb got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd2) begin failed++; $display("FAIL lw_cnt_hold got=%0d exp=2", InstrCnt); end
    tests++;
    cyc();
    #1 if (InstrCnt !== 16'd3) begin failed++; $display("FAIL lw_cnt got=%0d exp=3", InstrCnt); end
    tests++;
  endtask

  task automatic test_sw_stall;
    operation = 6'h2B; MemRdy = 1'b1;
    cyc(); cyc(); cyc();
    Stall = 1'b1;
    #1 exp_v = ev(4'd6, IOD, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL sw_stall0 got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 if (obs !== exp_v) begin failed++; $display("FAIL sw_stall1 got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    Stall = 1'b0;
    #1 exp_v = ev(4'd6, IOD | MWR, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL sw_release got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd3) begin failed++; $display("FAIL sw_cnt_hold got=%0d exp=3", InstrCnt); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd1, MRD | IRW | PCW, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL sw_fetch got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd4) begin failed++; $display("FAIL sw_cnt got=%0d exp=4", InstrCnt); end
    tests++;
  endtask

  task automatic test_stall_fetch;
    MemRdy = 1'b1; Stall = 1'b1;
    #1 exp_v = ev(4'd1, MRD, 2'b01, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL stall_fetch_out got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 if (obs !== exp_v) begin failed++; $display("FAIL stall_fetch_hold got=%h exp=%h", obs, exp_v); end
    tests++;
    Stall = 1'b0; MemRdy = 1'b0;
    cyc();
    #1 if (obs !== exp_v) begin failed++; $display("FAIL fetch_lost_rdy got=%h exp=%h", obs, exp_v); end
    tests++;
  endtask

  task automatic test_branch;
    operation = 6'h04; MemRdy = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4'd9, ASA | PCC, 2'b00, 2'b01, 4'd6);
    if (obs !== exp_v) begin failed++; $display("FAIL beq_branch got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 if (InstrCnt !== 16'd5) begin failed++; $display("FAIL beq_cnt got=%0d exp=5", InstrCnt); end
    tests++;
  endtask

  task automatic test_imm;
    operation = 6'h0C; MemRdy = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4'd11, ASA | EXT, 2'b10, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL andi_iexec got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 exp_v = ev(4'd12, RGW, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL andi_iwb got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    operation = 6'h08;
    cyc(); cyc();
    #1 exp_v = ev(4'd11, ASA, 2'b10, 2'b00, 4'd2);
    if (obs !== exp_v) begin failed++; $display("FAIL addi_iexec got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc(); cyc();
    #1 if (InstrCnt !== 16'd7) begin failed++; $display("FAIL imm_cnt got=%0d exp=7", InstrCnt); end
    tests++;
  endtask

  task automatic test_jump;
    operation = 6'h02; MemRdy = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4'd10, PCW, 2'b00, 2'b10, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL jump got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 if (InstrCnt !== 16'd8) begin failed++; $display("FAIL jump_cnt got=%0d exp=8", InstrCnt); end
    tests++;
  endtask

  task automatic test_bne;
    operation = 6'h05; MemRdy = 1'b1;
    cyc(); cyc();
`ifdef MC_BNE_EN
    #1 exp_v = ev(4'd9, ASA | PCC | BNE, 2'b00, 2'b01, 4'd6);
    if (obs !== exp_v) begin failed++; $display("FAIL bne_branch got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
    #1 if (InstrCnt !== 16'd9) begin failed++; $display("FAIL bne_cnt got=%0d exp=9", InstrCnt); end
    tests++;
`else
    exp_v = ev(4'd13, EXC, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < 12; i++) begin
      MemRdy = ~MemRdy;
      #1 if (obs !== exp_v) begin failed++; $display("FAIL bne_illegal%0d got=%h exp=%h", i, obs, exp_v); end
      tests++;
      cyc();
    end
    if (InstrCnt !== 16'd8) begin failed++; $display("FAIL illegal_cnt got=%0d exp=8", InstrCnt); end
    tests++;
    Rst = 1'b0;
    cyc();
    Rst = 1'b1;
    #1 exp_v = ev(4'd0, 13'h0, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL illegal_reset got=%h exp=%h", obs, exp_v); end
    tests++;
    cyc();
`endif
  endtask

  task automatic test_illegal_codes;
    operation = 6'h00; fcn = 6'h3F; MemRdy = 1'b1;
    cyc(); cyc(); cyc();
    #1 exp_v = ev(4'd13, EXC, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL bad_fcn got=%h exp=%h", obs, exp_v); end
    tests++;
    Stall = 1'b1; Rst = 1'b0;
    cyc();
    Rst = 1'b1;
    #1 exp_v = ev(4'd0, 13'h0, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL reset_over_stall got=%h exp=%h", obs, exp_v); end
    tests++;
    Stall = 1'b0;
    cyc();
    operation = 6'h3F;
    cyc(); cyc();
    #1 exp_v = ev(4'd13, EXC, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL bad_op got=%h exp=%h", obs, exp_v); end
    tests++;
  endtask

  task automatic test_wrap_and_reset_mid;
    Rst = 1'b0; Stall = 1'b0;
    cyc();
    Rst = 1'b1;
    cyc();
    operation = 6'h02; MemRdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc(); cyc(); cyc();
    end
    #1 if (s_InstrCnt !== 4'hF) begin failed++; $display("FAIL small_cnt_max got=%h exp=f", s_InstrCnt); end
    tests++;
    if (InstrCnt !== 16'd15) begin failed++; $display("FAIL cnt_15 got=%0d exp=15", InstrCnt); end
    tests++;
    operation = 6'h23;
    cyc(); cyc();
    MemRdy = 1'b0;
    cyc();
    #1 if (State !== 4'd4) begin failed++; $display("FAIL mid_memrd got=%0d exp=4", State); end
    tests++;
    Rst = 1'b0;
    cyc();
    Rst = 1'b1;
    #1 exp_v = ev(4'd0, 13'h0, 2'b00, 2'b00, 4'd0);
    if (obs !== exp_v) begin failed++; $display("FAIL reset_mid_idle got=%h exp=%h", obs, exp_v); end
    tests++;
    if (InstrCnt !== 16'd0 || s_InstrCnt !== 4'd0) begin
      failed++; $display("FAIL reset_mid_cnt got=%0d/%0d exp=0/0", InstrCnt, s_InstrCnt);
    end
    tests++;
    cyc();
    operation = 6'h02; MemRdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(); cyc(); cyc();
    end
    #1 if (s_InstrCnt !== 4'h0) begin failed++; $display("FAIL small_cnt_wrap got=%h exp=0", s_InstrCnt); end
    tests++;
    if (InstrCnt !== 16'd16) begin failed++; $display("FAIL cnt_16 got=%0d exp=16", InstrCnt); end
    tests++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch_wait();
    test_add();
    test_sub();
    test_lw_wait();
    test_sw_stall();
    test_stall_fetch();
    test_branch();
    test_imm();
    test_jump();
    test_bne();
    test_illegal_codes();
    test_wrap_and_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
